// File: rtl/regfile_reader_pkg.sv
// Shared definitions for the register-file burst reader: FSM encoding and default widths.
package regfile_reader_pkg;

  localparam int DEF_WIDTH     = 32;
  localparam int DEF_WORD_LINE = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  function automatic logic is_active(input state_e s);
    return s != IDLE;
  endfunction

endpackage

// File: rtl/regfile_reader_if.sv
// Bus bundle between a burst requester/consumer and the register-file reader.
interface regfile_reader_if
  import regfile_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int WORD_LINE = DEF_WORD_LINE
);

  logic                 start;
  logic [WORD_LINE-1:0] base;
  logic [WORD_LINE-1:0] count;
  logic                 abort;
  logic [WORD_LINE-1:0] ra;
  logic [WIDTH-1:0]     rd;
  logic [WIDTH-1:0]     out_data;
  logic [WORD_LINE-1:0] out_addr;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 done;

  modport master (
    output start, base, count, abort, rd, out_ready,
    input  ra, out_data, out_addr, out_valid, busy, done
  );

  modport slave (
    input  start, base, count, abort, rd, out_ready,
    output ra, out_data, out_addr, out_valid, busy, done
  );

endinterface

// File: rtl/regfile_reader_out.sv
// Output register stage: captures one word and its address, holds it while the consumer stalls.
module regfile_reader_out
  import regfile_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int WORD_LINE = DEF_WORD_LINE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     din,
  input  logic [WORD_LINE-1:0] ain,
  output logic [WIDTH-1:0]     out_data,
  output logic [WORD_LINE-1:0] out_addr,
  output logic                 out_valid
);

  logic [WIDTH-1:0]     data_p1;
  logic [WORD_LINE-1:0] addr_p1;
  logic                 vld_p1;

  // p0 -> p1: register-file read data captured into the offered word
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p1 <= '0;
      addr_p1 <= '0;
      vld_p1  <= 1'b0;
    end else if (clear) begin
      vld_p1  <= 1'b0;
    end else if (load) begin
      data_p1 <= din;
      addr_p1 <= ain;
      vld_p1  <= 1'b1;
    end
  end

  assign out_data  = data_p1;
  assign out_addr  = addr_p1;
  assign out_valid = vld_p1;

endmodule

// File: rtl/regfile_reader.sv
// Burst reader: walks a register-file read port from base for count words and streams them out.
module regfile_reader
  import regfile_reader_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int WORD_LINE = DEF_WORD_LINE
) (
  input  logic            clk,
  input  logic            rst,
  regfile_reader_if.slave bus
);

  state_e               state_q, state_d;
  logic [WORD_LINE-1:0] addr_p0;
  logic [WORD_LINE:0]   rem_p0;
  logic                 done_p1;

  logic                 take_start;
  logic                 load;
  logic                 accept_last;
  logic                 clear;

  logic [WIDTH-1:0]     data_w;
  logic [WORD_LINE-1:0] oaddr_w;
  logic                 vld_w;

  // A zero count encodes a full sweep of the register file.
  function automatic logic [WORD_LINE:0] burst_len(input logic [WORD_LINE-1:0] c);
    if (c == '0) return {1'b1, {WORD_LINE{1'b0}}};
    return {1'b0, c};
  endfunction

  always_comb begin
    state_d     = state_q;
    take_start  = 1'b0;
    load        = 1'b0;
    accept_last = 1'b0;
    clear       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.abort) begin
          take_start = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        if (bus.abort) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (!vld_w || bus.out_ready) begin
          load = 1'b1;
          if (rem_p0 == (WORD_LINE+1)'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.abort) begin
          clear   = 1'b1;
          state_d = IDLE;
        end else if (vld_w && bus.out_ready) begin
          accept_last = 1'b1;
          clear       = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // p0: control state, read address and words still to fetch
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_p0 <= '0;
      rem_p0  <= '0;
      done_p1 <= 1'b0;
    end else begin
      state_q <= state_d;
      done_p1 <= accept_last;
      if (take_start) begin
        addr_p0 <= bus.base;
        rem_p0  <= burst_len(bus.count);
      end else if (load) begin
        addr_p0 <= addr_p0 + WORD_LINE'(1);
        rem_p0  <= rem_p0 - (WORD_LINE+1)'(1);
      end
    end
  end

  regfile_reader_out #(
    .WIDTH     (WIDTH),
    .WORD_LINE (WORD_LINE)
  ) u_out (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .clear     (clear),
    .din       (bus.rd),
    .ain       (addr_p0),
    .out_data  (data_w),
    .out_addr  (oaddr_w),
    .out_valid (vld_w)
  );

  assign bus.ra        = addr_p0;
  assign bus.out_data  = data_w;
  assign bus.out_addr  = oaddr_w;
  assign bus.out_valid = vld_w;
  assign bus.busy      = is_active(state_q);
  assign bus.done      = done_p1;

endmodule

// File: doc/regfile_reader.md
REGFILE_READER -- requirements
Module: regfile_reader

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter WORD_LINE, default 3, register-file address width; depth is 2^WORD_LINE.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  request a readout burst; sampled only in IDLE.
REQ-006 base  input  WORD_LINE  first register address of the burst, sampled with start.
REQ-007 count  input  WORD_LINE  number of words to read, sampled with start; 0 means 2^WORD_LINE.
REQ-008 abort  input  1  cancel the burst in progress.
REQ-009 ra  output  WORD_LINE  read address to the register-file read port.
REQ-010 rd  input  WIDTH  combinational read data from the register file for ra.
REQ-011 out_data  output  WIDTH  registered word being offered.
REQ-012 out_addr  output  WORD_LINE  register address out_data came from.
REQ-013 out_valid  output  1  out_data/out_addr are valid.
REQ-014 out_ready  input  1  consumer accepts the word when out_valid && out_ready at a rising edge.
REQ-015 busy  output  1  high from the cycle after an accepted start until the cycle after the last transfer or abort.
REQ-016 done  output  1  one-cycle pulse after the last word of a burst is accepted.

Function
REQ-017 FSM states IDLE, READ, DRAIN; reset state IDLE.
REQ-018 IDLE: start=1 -> latch addr<=base, remaining<=count (0 maps to 2^WORD_LINE), go to READ; start=0 -> stay.
REQ-019 ra SHALL equal the internal address register in every state, 0 in IDLE after reset.
REQ-020 READ: when out_valid=0 or out_ready=1, load out_data<=rd, out_addr<=addr, out_valid<=1, addr<=addr+1 mod 2^WORD_LINE, remaining<=remaining-1.
REQ-021 READ: when remaining reaches 0 on a load, go to DRAIN.
REQ-022 DRAIN: on out_valid && out_ready, clear out_valid, pulse done for one cycle, go to IDLE.
REQ-023 out_valid=1 && out_ready=0: out_data, out_addr, addr and remaining SHALL hold unchanged.
REQ-024 Throughput SHALL be one word per cycle with out_ready held high; first out_valid appears 2 cycles after the start edge.
REQ-025 Latency from start edge to done for count=N with out_ready=1: N+2 cycles.
REQ-026 Address wraps from 2^WORD_LINE-1 to 0 within a burst.
REQ-027 start while busy SHALL be ignored.
REQ-028 abort in READ or DRAIN: next edge -> IDLE, out_valid<=0, no done pulse; abort takes priority over a simultaneous transfer.
REQ-029 abort in IDLE SHALL have no effect; abort and start together in IDLE: abort wins, start dropped.
REQ-030 remaining counter SHALL be WORD_LINE+1 bits wide.

Reset
REQ-031 rst=1 at a rising edge: state IDLE, addr=0, remaining=0, out_data=0, out_addr=0, out_valid=0, busy=0, done=0.
REQ-032 rst mid-burst SHALL discard the burst without a done pulse; rst overrides start and abort.

Structure
REQ-033 Shared package holds the FSM state encoding (IDLE=0, READ=1, DRAIN=2) and the default WIDTH/WORD_LINE constants.
REQ-034 One sub-module, regfile_reader_out: the output register stage (out_data/out_addr/out_valid with hold-on-stall); FSM and counters stay in the top.
REQ-035 Bench instantiates register (WIDTH 32, WORD_LINE 3) as the rd source.

Verification
REQ-036 Preload reg[i]=10*(i+1); start base=0 count=0, out_ready=1 -> 8 words 10..80 at addr 0..7 on consecutive cycles, done at cycle 10.
REQ-037 base=6 count=4 -> words 70,80,10,20 with out_addr 6,7,0,1 (wrap), done once.
REQ-038 base=2 count=3, out_ready low for 3 cycles on 2nd word -> out_data holds 40 during the stall, sequence 30,40,50 with no loss or duplication.
REQ-039 abort 2 cycles into base=0 count=0 -> out_valid low next cycle, busy low, done never pulses; new start then succeeds.
REQ-040 rst asserted during DRAIN -> all outputs 0 next cycle; start during busy -> ignored, burst completes unchanged.
